// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the data-RAM arbiter.
//   - RAM width-op codes and the fixed op used for instruction fetches
//   - arbiter FSM state codes
//   - requester id type used for grant bookkeeping
package mem_arb_pkg;

  localparam int WDT_TYPE_CNT = 2;

  localparam logic [WDT_TYPE_CNT-1:0] WDT8  = 2'd0;
  localparam logic [WDT_TYPE_CNT-1:0] WDT16 = 2'd1;
  localparam logic [WDT_TYPE_CNT-1:0] WDT32 = 2'd2;
  localparam logic [WDT_TYPE_CNT-1:0] WDT64 = 2'd3;

  // Fetches are always a full 32-bit instruction word.
  localparam logic [WDT_TYPE_CNT-1:0] IFU_OP = WDT32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   ifu_valid, lsu_valid : requests
//   last_grant           : requester served most recently
//   gnt_ifu, gnt_lsu     : one-hot (or zero) grant
// On a tie the requester that was not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic    ifu_valid,
  input  logic    lsu_valid,
  input  req_id_e last_grant,
  output logic    gnt_ifu,
  output logic    gnt_lsu
);

  assign gnt_ifu = ifu_valid && (!lsu_valid || (last_grant == REQ_LSU));
  assign gnt_lsu = lsu_valid && (!ifu_valid || (last_grant == REQ_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data RAM between the IFU and the LSU.
// Each access runs IDLE -> ISSUE -> RESP with one access outstanding.
//   clk, rst                 : clock, async active-high reset
//   ifu_req_*/ifu_addr       : fetch request channel (read-only, 32-bit)
//   ifu_resp_*/ifu_rdata     : fetch response channel
//   lsu_req_*/lsu_addr/...   : load/store request channel
//   lsu_resp_*/lsu_rdata     : load data / store completion
//   mem_*/wdt_op             : RAM control; mem_rdata valid one cycle after issue
//
// state   | meaning
// S_IDLE  | arbitrate, accept one request
// S_ISSUE | drive RAM strobe for exactly one cycle
// S_RESP  | present response to grantee until it is consumed
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int WADDR_W = 32,
  parameter int DATA_W  = 64,
  parameter int WDT_W   = WDT_TYPE_CNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [ADDR_W-1:0]  ifu_addr,
  output logic               ifu_resp_valid,
  input  logic               ifu_resp_ready,
  output logic [31:0]        ifu_rdata,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [ADDR_W-1:0]  lsu_addr,
  input  logic               lsu_wen,
  input  logic [DATA_W-1:0]  lsu_wdata,
  input  logic [WDT_W-1:0]   lsu_wdt_op,
  output logic               lsu_resp_valid,
  input  logic               lsu_resp_ready,
  output logic [DATA_W-1:0]  lsu_rdata,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [WADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [WDT_W-1:0]   wdt_op,
  input  logic [DATA_W-1:0]  mem_rdata
);

  logic [1:0]        state;
  req_id_e           last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WDT_W-1:0]  op_q;
  logic              wen_q;

  logic gnt_ifu;
  logic gnt_lsu;
  logic in_idle;
  logic resp_hs;

  rr_arb2 u_rr_arb2 (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  // Ready is suppressed while reset is held so no handshake is seen at release.
  assign in_idle       = (state == S_IDLE) && !rst;
  assign ifu_req_ready = in_idle && gnt_ifu;
  assign lsu_req_ready = in_idle && gnt_lsu;

  // last_grant doubles as the id of the requester owning the current access.
  assign ifu_resp_valid = (state == S_RESP) && (last_grant == REQ_IFU);
  assign lsu_resp_valid = (state == S_RESP) && (last_grant == REQ_LSU);
  assign resp_hs        = (ifu_resp_valid && ifu_resp_ready) ||
                          (lsu_resp_valid && lsu_resp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= REQ_LSU;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      wen_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ifu_req_ready) begin
            // Fetch addresses are forced word-aligned.
            addr_q     <= ifu_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            wdata_q    <= '0;
            op_q       <= WDT_W'(IFU_OP);
            wen_q      <= 1'b0;
            last_grant <= REQ_IFU;
            state      <= S_ISSUE;
          end else if (lsu_req_ready) begin
            addr_q     <= lsu_addr;
            wdata_q    <= lsu_wdata;
            op_q       <= lsu_wdt_op;
            wen_q      <= lsu_wen;
            last_grant <= REQ_LSU;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_RESP;
        S_RESP: begin
          if (resp_hs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address and op stay on the bus after issue: the RAM's lane select is live.
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q[WADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign wdt_op    = op_q;
  assign mem_ren   = (state == S_ISSUE) && !wen_q;
  assign mem_wen   = (state == S_ISSUE) && wen_q;

  assign ifu_rdata = !ifu_resp_valid ? 32'd0 :
                     addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign lsu_rdata = (lsu_resp_valid && !wen_q) ? mem_rdata : '0;

endmodule
